alu_issue: RTL

//  Decode/operand-issue stage directly upstream of the RV32I ALU. Accepts an instruction

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_decode.sv | 110 +++++++++++
 rtl/alu_issue.sv | 113 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue slice: ALU operation codes, the RV32I
// opcodes and funct7 values this stage decodes, and the registered issue payload.
package alu_pkg;

    localparam int XLEN = 32;

    // ALU operation encoding understood by the downstream ALU
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    // Major opcodes handled here; everything else is reported as illegal
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // funct7 values: plain form and the SUB/SRA alternate form
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Everything the ALU/writeback side needs for one instruction
    typedef struct packed {
        logic [XLEN-1:0] operand1;
        logic [XLEN-1:0] operand2;
        logic [3:0]      operation;
        logic [4:0]      rd;
        logic            we;
        logic            illegal;
    } issue_t;

endpackage

// File: rtl/alu_decode.sv
// Purely combinational decoder: instruction word plus rs1/rs2/pc become the
// issue payload (ALU op, both operands, rd, write enable, illegal flag).
module alu_decode
    import alu_pkg::*;
(
    input  logic [XLEN-1:0] inst,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] pc,
    output issue_t          payload
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];
    assign rd     = inst[11:7];

    // Source register indices are resolved upstream; only their values arrive here.
    logic unused_rs1_index;
    assign unused_rs1_index = &{1'b0, inst[19:15]};

    // Field-based decode; an undecodable word collapses to ADD 0,0 with illegal set
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can
        // leave one unassigned and infer a latch.
        payload           = '0;
        payload.operation = ALU_ADD;
        payload.illegal   = 1'b1;

        unique case (opcode)
            OPC_OP: begin
                payload.operand1 = rs1;
                payload.operand2 = rs2;
                if (funct7 == F7_BASE) begin
                    payload.illegal = 1'b0;
                    unique case (funct3)
                        3'b000: payload.operation = ALU_ADD;
                        3'b001: payload.operation = ALU_SLL;
                        3'b010: payload.operation = ALU_SLT;
                        3'b011: payload.operation = ALU_SLTU;
                        3'b100: payload.operation = ALU_XOR;
                        3'b101: payload.operation = ALU_SRL;
                        3'b110: payload.operation = ALU_OR;
                        3'b111: payload.operation = ALU_AND;
                    endcase
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    payload.illegal   = 1'b0;
                    payload.operation = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    payload.illegal   = 1'b0;
                    payload.operation = ALU_SRA;
                end
            end

            OPC_OP_IMM: begin
                payload.operand1 = rs1;
                payload.operand2 = {{20{inst[31]}}, inst[31:20]};
                payload.illegal  = 1'b0;
                unique case (funct3)
                    // ADDI ignores inst[30]: there is no SUBI
                    3'b000: payload.operation = ALU_ADD;
                    3'b010: payload.operation = ALU_SLT;
                    3'b011: payload.operation = ALU_SLTU;
                    3'b100: payload.operation = ALU_XOR;
                    3'b110: payload.operation = ALU_OR;
                    3'b111: payload.operation = ALU_AND;
                    3'b001: begin
                        payload.operand2  = {27'b0, inst[24:20]};
                        payload.operation = ALU_SLL;
                        payload.illegal   = (funct7 != F7_BASE);
                    end
                    3'b101: begin
                        payload.operand2  = {27'b0, inst[24:20]};
                        payload.operation = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        payload.illegal   = (funct7 != F7_BASE) && (funct7 != F7_ALT);
                    end
                endcase
            end

            OPC_LUI: begin
                payload.operand2 = {inst[31:12], 12'b0};
                payload.illegal  = 1'b0;
            end

            OPC_AUIPC: begin
                payload.operand1 = pc;
                payload.operand2 = {inst[31:12], 12'b0};
                payload.illegal  = 1'b0;
            end

            default: ;
        endcase

        // Illegal words carry no operands so nothing stale leaks downstream
        if (payload.illegal) begin
            payload.operand1  = '0;
            payload.operand2  = '0;
            payload.operation = ALU_ADD;
        end

        payload.rd = rd;
        payload.we = !payload.illegal && (rd != 5'd0);
    end

endmodule

// File: rtl/alu_issue.sv
// Issue register between decode and the RV32I ALU, behind valid/ready on both sides.
// Optional feature macro ALU_ISSUE_SKID_EN: adds a second (skid) entry so in_ready
// comes straight from a flop instead of combinationally from out_ready.
module alu_issue
    import alu_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_inst,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_operand1,
    output logic [XLEN-1:0] out_operand2,
    output logic [3:0]      out_operation,
    output logic [4:0]      out_rd,
    output logic            out_we,
    output logic            out_illegal
);

    // Only a 32-bit, word-aligned configuration makes sense for this stage
    if (XLEN != 32 || RESET_PC[1:0] != 2'b00) begin : g_param_check
        $error("alu_issue: XLEN must be 32 and RESET_PC word aligned");
    end

    issue_t dec;
    issue_t out_q;
    logic   out_valid_q;

    alu_decode u_decode (
        .inst    (in_inst),
        .rs1     (in_rs1),
        .rs2     (in_rs2),
        .pc      (in_pc),
        .payload (dec)
    );

`ifdef ALU_ISSUE_SKID_EN

    issue_t skid_q;
    logic   skid_valid_q;

    // Accept whenever the skid entry is free; purely a flop output
    assign in_ready = !skid_valid_q;

    // Valid bits and output register: skid drains first, stalled arrivals park in skid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_q        <= '0;
            skid_valid_q <= 1'b0;
        end else if (skid_valid_q) begin
            if (out_ready) begin
                out_q        <= skid_q;
                skid_valid_q <= 1'b0;
            end
        end else if (!out_valid_q || out_ready) begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                out_q <= dec;
            end
        end else if (in_valid) begin
            skid_valid_q <= 1'b1;
        end
    end

    // Skid payload capture; its contents only matter while skid_valid_q is set
    always_ff @(posedge clk) begin
        // NOTE: the skid data is never observed without its valid bit, so it is
        // left out of reset; only state that reaches the ports is reset.
        if (!skid_valid_q && out_valid_q && !out_ready && in_valid) begin
            skid_q <= dec;
        end
    end

`else

    // Single entry: accept when empty or when the held op leaves this cycle
    assign in_ready = !out_valid_q || out_ready;

    // Issue register: load on input transfer, clear valid when drained with nothing new
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state updates use non-blocking assignments so every flop samples
        // pre-edge values regardless of statement order.
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else if (in_ready) begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                out_q <= dec;
            end
        end
    end

`endif

    assign out_valid     = out_valid_q;
    assign out_operand1  = out_q.operand1;
    assign out_operand2  = out_q.operand2;
    assign out_operation = out_q.operation;
    assign out_rd        = out_q.rd;
    assign out_we        = out_q.we;
    assign out_illegal   = out_q.illegal;

endmodule
